// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: memory waits, load-use, redirects, halt drain.
// Also keeps saturating stall and flush counters for performance debug.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             idex_dMemREN,
    input  logic             idex_halt,
    input  logic             ex_redirect,
    input  logic             exmem_dMemREN,
    input  logic             exmem_dMemWEN,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [DW-1:0]    r_drain_cnt;
    logic [DW-1:0]    w_drain_nxt;
    logic             r_halt;
    logic             w_halt_set;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_dwait;
    logic w_lu;
    logic w_stall;
    logic w_flush_any;

    assign w_dwait = (exmem_dMemREN | exmem_dMemWEN) & ~dhit;
    assign w_lu    = idex_dMemREN & (idex_rt != '0) &
                     ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        w_stall     = 1'b0;
        w_halt_set  = 1'b0;
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        if (RST) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_dwait) begin
                        // Whole pipe frozen; redirect and load-use are re-evaluated later.
                        w_stall = 1'b1;
                    end else if (ex_redirect) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (idex_halt) begin
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        ifid_flush  = 1'b1;
                        w_state_nxt = StDrain;
                        w_drain_nxt = DW'(DRAIN_CYCLES);
                    end else if (w_lu) begin
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        idex_flush = 1'b1;
                        w_stall    = 1'b1;
                    end else if (!ihit) begin
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        w_stall    = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                StDrain: begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = ~w_dwait;
                    memwb_en   = ~w_dwait;
                    if (!w_dwait) begin
                        if (r_drain_cnt <= DW'(1)) begin
                            w_state_nxt = StHalted;
                            w_halt_set  = 1'b1;
                        end else begin
                            w_drain_nxt = r_drain_cnt - DW'(1);
                        end
                    end
                end
                StHalted: begin
                end
                default: begin
                    w_state_nxt = StRun;
                end
            endcase
        end
    end

    assign w_flush_any = ~RST & (ifid_flush | idex_flush);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= StRun;
            r_drain_cnt <= '0;
            r_halt      <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            if (w_halt_set) begin
                r_halt <= 1'b1;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_any && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign halt        = r_halt & ~RST;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus hand-written halt/wait sequences.
// A narrow-counter second instance shares the stimulus to exercise saturation.
module tb_pipe_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ihit, dhit, idex_dMemREN, idex_halt, ex_redirect, exmem_dMemREN, exmem_dMemWEN;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halt;
    logic [31:0] stall_count, flush_count;
    logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic        s_ifid_flush, s_idex_flush, s_halt;
    logic [2:0]  s_stall_count, s_flush_count;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt),
        .idex_dMemREN(idex_dMemREN), .idex_halt(idex_halt), .ex_redirect(ex_redirect),
        .exmem_dMemREN(exmem_dMemREN), .exmem_dMemWEN(exmem_dMemWEN),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halt(halt), .stall_count(stall_count), .flush_count(flush_count)
    );

    pipe_hazard_ctrl #(.CNT_W(3)) dut_sat (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rt(idex_rt),
        .idex_dMemREN(idex_dMemREN), .idex_halt(idex_halt), .ex_redirect(ex_redirect),
        .exmem_dMemREN(exmem_dMemREN), .exmem_dMemWEN(exmem_dMemWEN),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
        .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .halt(s_halt), .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    // Output bundle order: pc, ifid_en, idex_en, exmem, memwb, ifid_flush, idex_flush.
    localparam logic [6:0] MFULL = 7'b1111111;
    localparam logic [6:0] MIF   = 7'b1011111;  // ifid_en ignored under ifid_flush
    localparam logic [6:0] MID   = 7'b1101111;  // idex_en ignored under idex_flush
    localparam logic [6:0] MBOTH = 7'b1001111;
    localparam logic [6:0] RUNO  = 7'b1111100;
    localparam logic [6:0] FLSH  = 7'b1111111;
    localparam logic [6:0] LUO   = 7'b0001101;
    localparam logic [6:0] NIHO  = 7'b0011110;

    typedef struct {
        string      name;
        logic [6:0] ctl;   // {ihit, dhit, ren, halt, redirect, mren, mwen}
        logic [4:0] rs, rt, xrt;
        logic [6:0] exp, msk;
        logic       h;
        int         st, fl;
    } vec_t;

    typedef struct {
        string      name;
        logic [6:0] exp, msk;
        logic       h;
    } sb_t;

    sb_t  sbq[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    function automatic vec_t mk(string name, logic [6:0] ctl, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] xrt, logic [6:0] exp, logic [6:0] msk, logic h,
                                int st, int fl);
        vec_t v;
        v.name = name; v.ctl = ctl; v.rs = rs; v.rt = rt; v.xrt = xrt;
        v.exp = exp; v.msk = msk; v.h = h; v.st = st; v.fl = fl;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic logic [6:0] outs();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
    endfunction

    // Starts and ends at posedge+1.
    task automatic step(vec_t v);
        sb_t e;
        {ihit, dhit, idex_dMemREN, idex_halt, ex_redirect, exmem_dMemREN, exmem_dMemWEN} = v.ctl;
        ifid_rs = v.rs;
        ifid_rt = v.rt;
        idex_rt = v.xrt;
        sbq.push_back('{v.name, v.exp, v.msk, v.h});
        @(negedge CLK);
        e = sbq.pop_front();
        chk({e.name, ".out"}, 64'(outs() & e.msk), 64'(e.exp & e.msk));
        chk({e.name, ".halt"}, 64'(halt), 64'(e.h));
        chk({e.name, ".stall_cnt"}, 64'(stall_count), 64'(exp_stall));
        chk({e.name, ".flush_cnt"}, 64'(flush_count), 64'(exp_flush));
        exp_stall += v.st;
        exp_flush += v.fl;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        {ihit, dhit, idex_dMemREN, idex_halt, ex_redirect, exmem_dMemREN, exmem_dMemWEN} = '1;
        ifid_rs = '1;
        ifid_rt = '1;
        idex_rt = '1;
        @(negedge CLK);
        chk("rst.out0", 64'(outs()), 64'(7'b0000011));
        chk("rst.halt0", 64'(halt), 64'(0));
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("rst.out1", 64'(outs()), 64'(7'b0000011));
        chk("rst.halt1", 64'(halt), 64'(0));
        chk("rst.stall_cnt", 64'(stall_count), 64'(0));
        chk("rst.flush_cnt", 64'(flush_count), 64'(0));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
    endtask

    initial begin
        vec_t n;
        n = mk("normal", 7'b1000000, 5'd1, 5'd2, 5'd3, RUNO, MFULL, 1'b0, 0, 0);

        tbl.push_back(n);
        tbl.push_back(mk("no_ihit",     7'b0000000, 5'd1, 5'd2, 5'd3, NIHO, MIF,   1'b0, 1, 1));
        tbl.push_back(mk("lu_rs",       7'b1010000, 5'd5, 5'd0, 5'd5, LUO,  MID,   1'b0, 1, 1));
        tbl.push_back(mk("lu_rt",       7'b1010000, 5'd3, 5'd7, 5'd7, LUO,  MID,   1'b0, 1, 1));
        tbl.push_back(mk("lu_r0",       7'b1010000, 5'd0, 5'd0, 5'd0, RUNO, MFULL, 1'b0, 0, 0));
        tbl.push_back(mk("no_load",     7'b1000000, 5'd5, 5'd5, 5'd5, RUNO, MFULL, 1'b0, 0, 0));
        tbl.push_back(mk("lu_nohit",    7'b0010000, 5'd9, 5'd4, 5'd9, LUO,  MID,   1'b0, 1, 1));
        tbl.push_back(mk("dwait_rd",    7'b1000010, 5'd1, 5'd2, 5'd3, 7'd0, MFULL, 1'b0, 1, 0));
        tbl.push_back(mk("dwait_wr",    7'b1000001, 5'd1, 5'd2, 5'd3, 7'd0, MFULL, 1'b0, 1, 0));
        tbl.push_back(mk("mem_hit",     7'b1100011, 5'd1, 5'd2, 5'd3, RUNO, MFULL, 1'b0, 0, 0));
        tbl.push_back(mk("redir_nohit", 7'b0000100, 5'd1, 5'd2, 5'd3, FLSH, MBOTH, 1'b0, 0, 1));
        tbl.push_back(mk("redir_lu",    7'b1010100, 5'd6, 5'd2, 5'd6, FLSH, MBOTH, 1'b0, 0, 1));
        tbl.push_back(mk("dwait_redir", 7'b1000110, 5'd1, 5'd2, 5'd3, 7'd0, MFULL, 1'b0, 1, 0));
        tbl.push_back(mk("redir_halt",  7'b1001100, 5'd1, 5'd2, 5'd3, FLSH, MBOTH, 1'b0, 0, 1));
        tbl.push_back(mk("after_rh",    7'b1000000, 5'd1, 5'd2, 5'd3, RUNO, MFULL, 1'b0, 0, 0));

        @(posedge CLK);
        #1;
        do_reset();
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Data wait holding a redirect for three cycles.
        do_reset();
        for (int i = 0; i < 3; i++)
            step(mk("dw_hold", 7'b1000110, 5'd1, 5'd2, 5'd3, 7'd0, MFULL, 1'b0, 1, 0));
        step(mk("dw_release", 7'b1100110, 5'd1, 5'd2, 5'd3, FLSH, MBOTH, 1'b0, 0, 1));
        step(mk("dw_after", 7'b1000000, 5'd1, 5'd2, 5'd3, RUNO, MFULL, 1'b0, 0, 0));

        // Halt drain with one stalled MEM cycle: halt visible four cycles after entry.
        do_reset();
        step(mk("h_entry",  7'b1001000, 5'd1, 5'd2, 5'd3, 7'b0011110, MIF,   1'b0, 0, 1));
        step(mk("h_drain1", 7'b1000000, 5'd1, 5'd2, 5'd3, 7'b0001111, MBOTH, 1'b0, 0, 1));
        step(mk("h_dwait",  7'b1000010, 5'd1, 5'd2, 5'd3, 7'b0000011, MBOTH, 1'b0, 0, 1));
        step(mk("h_drain2", 7'b1100010, 5'd1, 5'd2, 5'd3, 7'b0001111, MBOTH, 1'b0, 0, 1));
        step(mk("h_halted", 7'b1000000, 5'd1, 5'd2, 5'd3, 7'd0, MFULL, 1'b1, 0, 0));
        step(mk("h_hold",   7'b0001110, 5'd1, 5'd2, 5'd3, 7'd0, MFULL, 1'b1, 0, 0));
        do_reset();
        step(mk("h_rst_run", 7'b1000000, 5'd1, 5'd2, 5'd3, RUNO, MFULL, 1'b0, 0, 0));

        // Reset in the middle of draining.
        step(mk("d_entry", 7'b1001000, 5'd1, 5'd2, 5'd3, 7'b0011110, MIF, 1'b0, 0, 1));
        do_reset();
        step(mk("d_rst_run", 7'b1000000, 5'd1, 5'd2, 5'd3, RUNO, MFULL, 1'b0, 0, 0));
        step(mk("d_rst_run2", 7'b1000000, 5'd1, 5'd2, 5'd3, RUNO, MFULL, 1'b0, 0, 0));

        // Narrow counters must stick at all-ones.
        do_reset();
        for (int i = 0; i < 10; i++)
            step(mk("sat", 7'b0000000, 5'd1, 5'd2, 5'd3, NIHO, MIF, 1'b0, 1, 1));
        chk("sat.stall_cnt", 64'(s_stall_count), 64'(3'h7));
        chk("sat.flush_cnt", 64'(s_flush_count), 64'(3'h7));
        chk("sat.main_stall", 64'(stall_count), 64'(10));

        chk("sb.empty", 64'(sbq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Resolves instruction-memory wait, data-memory wait, load-use hazards, EX-stage redirects (taken branch / jump / JR) and halt draining.
- Produces per-latch enable and flush strobes.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
- REG_W, 5, register index width
- CNT_W, 32, width of stall_count and flush_count
- DRAIN_CYCLES, 2, pipeline advances needed after halt leaves ID/EX before halt asserts (EX->MEM->WB)

Ports:
- CLK  in  1  single clock; all state updates on posedge CLK
- RST  in  1  synchronous, active-high reset
- ihit  in  1  instruction fetch for current PC complete this cycle
- dhit  in  1  data access at MEM stage complete this cycle
- ifid_rs  in  REG_W  rs field of instruction in IF/ID
- ifid_rt  in  REG_W  rt field of instruction in IF/ID
- idex_rt  in  REG_W  load destination (rt_out of ID/EX)
- idex_dMemREN  in  1  ID/EX holds a load
- idex_halt  in  1  ID/EX holds a halt
- ex_redirect  in  1  EX resolves a taken branch/jump; PC mux selects target this cycle
- exmem_dMemREN, exmem_dMemWEN  in  1 each  MEM stage memory request
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch load enables
- ifid_flush, idex_flush  out  1 each  latch loads all-zero bubble at next edge; overrides en
- halt  out  1  sticky processor-halted flag
- stall_count  out  CNT_W  cycles with any stage frozen or bubbled by a hazard
- flush_count  out  CNT_W  cycles with ifid_flush or idex_flush asserted, excluding RST

Behaviour:
- States: RUN, DRAIN, HALTED. Register drain_cnt holds up to DRAIN_CYCLES.
- RST=1 at posedge: state<=RUN, drain_cnt<=0, halt<=0, counters<=0.
- While RST=1, outputs: all *_en=0, ifid_flush=idex_flush=1, halt=0.
- Outputs are combinational from state and inputs. halt and the counters are registered.
- Definitions:
  - dwait = (exmem_dMemREN|exmem_dMemWEN) & !dhit
  - lu = idex_dMemREN & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt)
- RUN priority, highest first:
  1. dwait: all en=0, no flush (entire pipe frozen). Redirect and lu are held and re-evaluated next cycle.
  2. ex_redirect: all en=1, ifid_flush=1, idex_flush=1. PC loads target regardless of ihit.
  3. lu: pc_en=0, ifid_en=0, idex_flush=1; exmem_en=memwb_en=1. Exactly one bubble per load-use pair.
  4. !ihit: pc_en=0, ifid_flush=1; downstream en=1.
  5. Otherwise: all en=1, no flush.
- Halt entry: in RUN, idex_halt=1 and not dwait -> next state DRAIN, drain_cnt<=DRAIN_CYCLES.
  - Entry cycle outputs: pc_en=0, ifid_flush=1; halt latch advances normally.
  - A redirect in the same cycle takes priority and flushes the halt (speculative halt discarded); remain RUN.
- DRAIN:
  - pc_en=0, ifid_flush=1, idex_flush=1 always.
  - exmem_en=memwb_en=!dwait.
  - drain_cnt decrements only on non-dwait cycles.
  - When drain_cnt reaches 1 and the cycle is non-dwait: next state HALTED, halt<=1.
- HALTED: all en=0, flushes=0, halt=1 until RST.
- Counters increment by 1 per qualifying cycle, saturate at all-ones, and never wrap.
  - stall_count: cycles where any of dwait, lu, or !ihit selected the output in RUN.
  - flush_count: as defined in Ports.
- Simultaneous lu and !ihit: lu wins; ifid_en=0 holds the instruction, no ifid bubble.
- RST mid-DRAIN or in HALTED: returns to RUN next cycle; no residual halt.

Test Plan:
- Reset: RST=1 for 2 cycles with all inputs 1 -> all en=0, both flush=1, halt=0, counters 0. After release with ihit=1, all en=1 on the next cycle.
- Load-use: idex_dMemREN=1, idex_rt=5, ifid_rs=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, stall_count=1. With idex_rt=0 -> no stall.
- Data wait: exmem_dMemREN=1, dhit=0 for 3 cycles with ex_redirect=1 -> all en=0 for 3 cycles; redirect flush asserts on the cycle dhit=1; stall_count=3, flush_count=1.
- Redirect vs ihit: ex_redirect=1, ihit=0 -> pc_en=1, ifid_flush=idex_flush=1.
- Halt drain: idex_halt=1, then dhit=0 for 1 MEM cycle -> halt rises exactly 4 cycles after entry (1 entry + 2 drain advances + 1 stalled); all en=0 afterward.
- Saturation: preload via force/long run with stall_count=all-ones, apply !ihit -> count stays all-ones.
